// File: rtl/i2c_mst_ctrl_byte_pkg.sv
// Shared command encodings for the I2C master byte sequencer and its bit controller.
// Values track i2c_master_defines.v.
package i2c_mst_ctrl_byte_pkg;

    localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
    localparam logic [3:0] I2C_CMD_WAIT  = 4'b0011;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
    localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

endpackage

// File: rtl/i2c_mst_ctrl_byte.sv
// Byte-level I2C command sequencer: expands host byte requests into START / 8 data bits /
// ACK bit / STOP commands for the bit controller, one done pulse per request.
module i2c_mst_ctrl_byte
    import i2c_mst_ctrl_byte_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       stop,
    input  logic       write,
    input  logic       read,
    input  logic       ack_in,
    input  logic       hold,
    input  logic [7:0] din,
    output logic       done,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       busy,
    output logic       al_o,
    output logic [3:0] core_cmd,
    output logic       core_txd,
    input  logic       core_ack,
    input  logic       core_rxd,
    input  logic       core_al
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP, ST_WAIT
    } state_t;

    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_cnt;
    logic       r_wasWrite;

    // The next command is loaded on the same edge that sees core_ack, so the bit
    // controller never idles between bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_sr       <= 8'h00;
            r_cnt      <= 3'd0;
            r_wasWrite <= 1'b0;
            core_cmd   <= I2C_CMD_NOP;
            core_txd   <= 1'b1;
            done       <= 1'b0;
            ack_out    <= 1'b0;
            dout       <= 8'h00;
            busy       <= 1'b0;
            al_o       <= 1'b0;
        end else begin
            done <= 1'b0;
            al_o <= 1'b0;
            if (core_al) begin
                r_state  <= ST_IDLE;
                core_cmd <= I2C_CMD_NOP;
                busy     <= 1'b0;
                al_o     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start || write || read) begin
                            r_sr       <= din;
                            r_cnt      <= 3'd7;
                            r_wasWrite <= write;
                        end
                        if (start) begin
                            r_state  <= ST_START;
                            core_cmd <= I2C_CMD_START;
                            busy     <= 1'b1;
                        end else if (write) begin
                            r_state  <= ST_WRITE;
                            core_cmd <= I2C_CMD_WRITE;
                            core_txd <= din[7];
                            busy     <= 1'b1;
                        end else if (read) begin
                            r_state  <= ST_READ;
                            core_cmd <= I2C_CMD_READ;
                            busy     <= 1'b1;
                        end else if (stop) begin
                            r_state  <= ST_STOP;
                            core_cmd <= I2C_CMD_STOP;
                            busy     <= 1'b1;
                        end else if (hold) begin
                            r_state  <= ST_WAIT;
                            core_cmd <= I2C_CMD_WAIT;
                            busy     <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (core_ack) begin
                            if (write) begin
                                r_state  <= ST_WRITE;
                                core_cmd <= I2C_CMD_WRITE;
                                core_txd <= r_sr[7];
                            end else if (read) begin
                                r_state  <= ST_READ;
                                core_cmd <= I2C_CMD_READ;
                            end else if (stop) begin
                                r_state  <= ST_STOP;
                                core_cmd <= I2C_CMD_STOP;
                            end else begin
                                r_state  <= ST_IDLE;
                                core_cmd <= I2C_CMD_NOP;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                dout     <= r_sr;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (core_ack) begin
                            r_sr <= {r_sr[6:0], 1'b0};
                            if (r_cnt == 3'd0) begin
                                r_state  <= ST_ACK;
                                core_cmd <= I2C_CMD_READ;
                            end else begin
                                r_cnt    <= r_cnt - 3'd1;
                                core_txd <= r_sr[6];
                            end
                        end
                    end
                    ST_READ: begin
                        if (core_ack) begin
                            r_sr <= {r_sr[6:0], core_rxd};
                            if (r_cnt == 3'd0) begin
                                r_state  <= ST_ACK;
                                core_cmd <= I2C_CMD_WRITE;
                                core_txd <= ack_in;
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (core_ack) begin
                            if (r_wasWrite) begin
                                ack_out <= core_rxd;
                            end
                            if (stop) begin
                                r_state  <= ST_STOP;
                                core_cmd <= I2C_CMD_STOP;
                            end else begin
                                r_state  <= ST_IDLE;
                                core_cmd <= I2C_CMD_NOP;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                dout     <= r_sr;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (core_ack) begin
                            r_state  <= ST_IDLE;
                            core_cmd <= I2C_CMD_NOP;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            dout     <= r_sr;
                        end
                    end
                    ST_WAIT: begin
                        if (!hold) begin
                            r_state  <= ST_IDLE;
                            core_cmd <= I2C_CMD_NOP;
                            busy     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        core_cmd <= I2C_CMD_NOP;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_mst_ctrl_byte.sv
// Self-checking bench for i2c_mst_ctrl_byte: a bit-controller model acks commands with
// random latency, and each byte's expected command stream is built from the request.
module tb_i2c_mst_ctrl_byte;
    import i2c_mst_ctrl_byte_pkg::*;

    typedef struct {
        logic [3:0] cmd;
        logic       txd;
    } cmdT;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic       ack_in = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] din = 8'h00;
    logic       done;
    logic       ack_out;
    logic [7:0] dout;
    logic       busy;
    logic       al_o;
    logic [3:0] core_cmd;
    logic       core_txd;
    logic       core_ack = 1'b0;
    logic       core_rxd = 1'b0;
    logic       core_al = 1'b0;

    int  nAsserts = 0;
    int  nFails = 0;
    int  cyc = 0;
    int  doneCount = 0;
    int  lastAckCycle = 0;
    int  alAt = -1;
    bit  expAckOut = 1'b0;
    cmdT logQ[$];
    bit  rxdQ[$];

    i2c_mst_ctrl_byte dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .write    (write),
        .read     (read),
        .ack_in   (ack_in),
        .hold     (hold),
        .din      (din),
        .done     (done),
        .ack_out  (ack_out),
        .dout     (dout),
        .busy     (busy),
        .al_o     (al_o),
        .core_cmd (core_cmd),
        .core_txd (core_txd),
        .core_ack (core_ack),
        .core_rxd (core_rxd),
        .core_al  (core_al)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) doneCount <= doneCount + 1;
    end

    // Bit-controller model: logs each issued command, then acks it (or raises
    // arbitration loss) after 0-2 idle cycles.
    always begin
        int idx;
        int lat;
        @(negedge clk);
        if (rstn && (core_cmd == I2C_CMD_START || core_cmd == I2C_CMD_STOP ||
                     core_cmd == I2C_CMD_WRITE || core_cmd == I2C_CMD_READ)) begin
            logQ.push_back(cmdT'{core_cmd, core_txd});
            idx = logQ.size();
            lat = int'($urandom_range(0, 2));
            repeat (lat) @(negedge clk);
            if (idx == alAt) begin
                core_al = 1'b1;
                @(negedge clk);
                core_al = 1'b0;
            end else begin
                if (core_cmd == I2C_CMD_READ && rxdQ.size() > 0) core_rxd = rxdQ.pop_front();
                else core_rxd = 1'($urandom_range(0, 1));
                core_ack = 1'b1;
                lastAckCycle = cyc;
                @(negedge clk);
                core_ack = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearRequests();
        start = 1'b0; stop = 1'b0; write = 1'b0; read = 1'b0; hold = 1'b0;
    endtask

    // One complete byte request; expected bit commands come straight from the request.
    task automatic applyStimulus(input bit s, input bit st, input bit w, input bit r, input bit a,
                                 input logic [7:0] d, input logic [7:0] rd, input bit ackBit);
        cmdT expQ[$];
        int  doneBefore;
        bit  gotDone;
        int  n;
        if (s) expQ.push_back(cmdT'{I2C_CMD_START, 1'b0});
        if (w) begin
            for (int i = 7; i >= 0; i--) expQ.push_back(cmdT'{I2C_CMD_WRITE, d[i]});
            expQ.push_back(cmdT'{I2C_CMD_READ, 1'b0});
        end else if (r) begin
            for (int i = 0; i < 8; i++) expQ.push_back(cmdT'{I2C_CMD_READ, 1'b0});
            expQ.push_back(cmdT'{I2C_CMD_WRITE, a});
        end
        if (st) expQ.push_back(cmdT'{I2C_CMD_STOP, 1'b0});
        logQ.delete();
        rxdQ.delete();
        if (w) rxdQ.push_back(ackBit);
        else if (r) for (int i = 7; i >= 0; i--) rxdQ.push_back(rd[i]);
        doneBefore = doneCount;
        start = s; stop = st; write = w; read = r; ack_in = a; din = d;
        @(negedge clk);
        checkOutput("firstCmd", 32'(core_cmd), 32'(expQ[0].cmd));
        gotDone = 1'b0;
        for (int c = 0; c < 300 && !gotDone; c++) begin
            if (done === 1'b1) gotDone = 1'b1;
            else begin
                checkOutput("busyHeld", 32'(busy), 32'd1);
                @(negedge clk);
            end
        end
        checkOutput("doneSeen", 32'(gotDone), 32'd1);
        clearRequests();
        if (!gotDone) return;
        checkOutput("doneLatency", 32'(cyc), 32'(lastAckCycle + 1));
        checkOutput("cmdNopAfter", 32'(core_cmd), 32'(I2C_CMD_NOP));
        checkOutput("busyAfter", 32'(busy), 32'd0);
        checkOutput("cmdCount", 32'(logQ.size()), 32'(expQ.size()));
        n = (logQ.size() < expQ.size()) ? logQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("cmd[%0d]", i), 32'(logQ[i].cmd), 32'(expQ[i].cmd));
            if (expQ[i].cmd == I2C_CMD_WRITE)
                checkOutput($sformatf("txd[%0d]", i), 32'(logQ[i].txd), 32'(expQ[i].txd));
        end
        if (w) expAckOut = ackBit;
        checkOutput("ackOut", 32'(ack_out), 32'(expAckOut));
        if (r && !w) checkOutput("dout", 32'(dout), 32'(rd));
        @(negedge clk);
        checkOutput("donePulse", 32'(done), 32'd0);
        checkOutput("doneCount", 32'(doneCount), 32'(doneBefore + 1));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".cmd"}, 32'(core_cmd), 32'(I2C_CMD_NOP));
        checkOutput({tag, ".txd"}, 32'(core_txd), 32'd1);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".ackOut"}, 32'(ack_out), 32'd0);
        checkOutput({tag, ".dout"}, 32'(dout), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".alO"}, 32'(al_o), 32'd0);
    endtask

    initial begin
        int  doneBefore;
        bit  seen;
        bit  rs, rst, rw, rr;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] start+write 0xA5 with ACK");
        applyStimulus(1, 0, 1, 0, 0, 8'hA5, 8'h00, 1'b0);

        $display("[TB] read+stop 0x3C with NACK");
        applyStimulus(0, 1, 0, 1, 1, 8'h00, 8'h3C, 1'b0);

        $display("[TB] stop only");
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 1'b0);

        $display("[TB] arbitration loss on 4th data bit");
        logQ.delete();
        rxdQ.delete();
        alAt = 5;
        doneBefore = doneCount;
        start = 1'b1; write = 1'b1; din = 8'($urandom);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (al_o === 1'b1) seen = 1'b1;
        end
        clearRequests();
        checkOutput("alSeen", 32'(seen), 32'd1);
        checkOutput("alCmdNop", 32'(core_cmd), 32'(I2C_CMD_NOP));
        checkOutput("alBusy", 32'(busy), 32'd0);
        checkOutput("alCmdCount", 32'(logQ.size()), 32'd5);
        alAt = -1;
        @(negedge clk);
        checkOutput("alPulse", 32'(al_o), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("alNoDone", 32'(doneCount), 32'(doneBefore));
        checkOutput("alIdleCmd", 32'(core_cmd), 32'(I2C_CMD_NOP));
        checkOutput("alAckOut", 32'(ack_out), 32'(expAckOut));

        $display("[TB] hold for 20 cycles");
        doneBefore = doneCount;
        hold = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("holdWait", 32'(core_cmd), 32'(I2C_CMD_WAIT));
            checkOutput("holdBusy", 32'(busy), 32'd1);
        end
        hold = 1'b0;
        @(negedge clk);
        checkOutput("holdRelease", 32'(core_cmd), 32'(I2C_CMD_NOP));
        @(negedge clk);
        checkOutput("holdIdle", 32'(busy), 32'd0);
        checkOutput("holdNoDone", 32'(doneCount), 32'(doneBefore));

        $display("[TB] reset mid-write");
        logQ.delete();
        rxdQ.delete();
        start = 1'b1; write = 1'b1; din = 8'($urandom);
        for (int c = 0; c < 100 && logQ.size() < 4; c++) @(negedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checkResetValues("midReset");
        clearRequests();
        expAckOut = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1, 0, 1, 0, 0, 8'($urandom), 8'h00, 1'($urandom_range(0, 1)));

        $display("[TB] random requests");
        for (int t = 0; t < 20; t++) begin
            rs  = 1'($urandom_range(0, 1));
            rst = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            rr  = 1'($urandom_range(0, 1));
            if (!(rs || rst || rw || rr)) rst = 1'b1;
            applyStimulus(rs, rst, rw, rr, 1'($urandom_range(0, 1)), 8'($urandom),
                          8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
